if_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the control decoder. Holds the PC,

---
 rtl/if_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited fetch over req/gnt/rvalid, FIFO_DEPTH-entry
// instruction buffer, valid/ready decode handshake and NPCOp redirect with wrong-path flush.
// Optional IF_PERF_CNT_EN adds perf_fetched/perf_flushed counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [2:0]  NPCOp,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [6:0]  Op,
  output logic [6:0]  Funct7,
  output logic [2:0]  Funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_q, rd_q;
  logic            req_q, req_d;
  logic            vld_q, vld_d;
  logic            clear;
  entry_t          fifo_q [FIFO_DEPTH];
  entry_t          head;

  logic            grant, rv, push, pop, redir;
  logic [31:0]     br_target, jr_sum, raw_target, target;

  assign grant = req_q & imem_gnt;
  // responses with nothing outstanding are protocol errors and are ignored
  assign rv    = imem_rvalid & (out_q != '0);
  assign pop   = vld_q & id_ready;
  assign redir = redirect_valid &
                 ((NPCOp == 3'b001) | (NPCOp == 3'b010) | (NPCOp == 3'b100));
  assign push  = rv & (state_q == RUN) & ~redir;

  // redirect target; jalr clears bit 0, every target is word aligned
  assign br_target  = redirect_pc + imm;
  assign jr_sum     = rs1_val + imm;
  assign raw_target = (NPCOp == 3'b100) ? (jr_sum & ~32'h1) : br_target;
  assign target     = {raw_target[31:2], 2'b00};

  // next-state, credit accounting and registered-output precompute
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q + CW'(grant) - CW'(rv);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    clear      = 1'b0;
    if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
    if (push)  rsp_pc_d   = rsp_pc_q + 32'd4;
    if (redir) begin
      // everything still in flight after this cycle is wrong-path
      fetch_pc_d = target;
      rsp_pc_d   = target;
      cnt_d      = '0;
      clear      = 1'b1;
      state_d    = (out_d != '0) ? FLUSH : RUN;
    end else begin
      case (state_q)
        RUN:     state_d = RUN;
        FLUSH:   if (out_d == '0) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
    req_d = (state_d == RUN) && ((out_d + cnt_d) < CW'(FIFO_DEPTH));
    vld_d = (cnt_d != '0);
  end

  // state, PC, credit and pointer registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      vld_q      <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      vld_q      <= vld_d;
      if (clear) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + AW'(1);
        if (pop)  rd_q <= rd_q + AW'(1);
      end
    end
  end

  // instruction buffer storage
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= '{instr: imem_rdata, pc: rsp_pc_q};
  end

  assign head      = fifo_q[rd_q];
  assign imem_req  = req_q;
  assign imem_addr = fetch_pc_q;
  assign id_valid  = vld_q;
  assign id_instr  = head.instr;
  assign id_pc     = head.pc;
  assign id_pc4    = head.pc + 32'd4;
  assign Op        = head.instr[6:0];
  assign Funct7    = head.instr[31:25];
  assign Funct3    = head.instr[14:12];
  assign rs1       = head.instr[19:15];
  assign rs2       = head.instr[24:20];
  assign rd        = head.instr[11:7];

`ifdef IF_PERF_CNT_EN
  logic        drop;
  logic [31:0] flushed_inc;

  assign drop        = rv & ~push;
  assign flushed_inc = (redir ? 32'(cnt_q - CW'(pop)) : 32'd0) + 32'(drop);

  // delivered and discarded instruction counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_fetched <= 32'd0;
      perf_flushed <= 32'd0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_flushed <= perf_flushed + flushed_inc;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: in-order memory model, decode scoreboard,
// directed sequences and a redirect-target vector table.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [2:0]  NPCOp = 3'b000;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imm = '0;
  logic [31:0] rs1_val = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr, id_pc, id_pc4;
  logic [6:0]  Op, Funct7;
  logic [2:0]  Funct3;
  logic [4:0]  rs1, rs2, rd;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  if_fetch_unit dut (
    .clk(clk), .rstn(rstn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .NPCOp(NPCOp), .redirect_pc(redirect_pc),
    .imm(imm), .rs1_val(rs1_val),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc4(id_pc4), .Op(Op), .Funct7(Funct7), .Funct3(Funct3),
    .rs1(rs1), .rs2(rs2), .rd(rd)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // memory model state
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  bit          gnt_en = 1'b1;
  bit          hold = 1'b0;
  int          lat = 1;

  // scoreboard state
  logic [31:0] exp_pc, exp_fetch;
  int          nxfer, ngnt, first_g, first_v;

  typedef struct {
    logic        rv;
    logic [2:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] exp;
  } rvec_t;
  rvec_t tbl[10];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // close one clock cycle: log handshakes, advance, then drive memory for the next cycle
  task automatic tick();
    logic [31:0] w;
    if (rstn && imem_req && imem_gnt) begin
      check("imem_addr_seq", imem_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
      ngnt++;
      if (first_g < 0) first_g = cyc;
    end
    if (rstn && id_valid && id_ready) begin
      w = instr_of(exp_pc);
      check("id_pc", id_pc, exp_pc);
      check("id_instr", id_instr, w);
      check("id_pc4", id_pc4, exp_pc + 32'd4);
      check("Op", 32'(Op), 32'(w[6:0]));
      check("Funct7", 32'(Funct7), 32'(w[31:25]));
      check("Funct3", 32'(Funct3), 32'(w[14:12]));
      check("rs1", 32'(rs1), 32'(w[19:15]));
      check("rs2", 32'(rs2), 32'(w[24:20]));
      check("rd", 32'(rd), 32'(w[11:7]));
      exp_pc = exp_pc + 32'd4;
      nxfer++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    imem_gnt = gnt_en;
    if (rstn && !hold && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    if (id_valid && first_v < 0) first_v = cyc;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    NPCOp = 3'b000;
    pend_addr.delete();
    pend_due.delete();
    repeat (2) @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
`ifdef IF_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 32'd0);
    check("rst_perf_flushed", perf_flushed, 32'd0);
`endif
    rstn = 1'b1;
    cyc = 0;
    exp_pc = 32'h0;
    exp_fetch = 32'h0;
    first_g = -1;
    first_v = -1;
    nxfer = 0;
    ngnt = 0;
    imem_gnt = gnt_en;
  endtask

  task automatic redirect(input logic v, input logic [2:0] op, input logic [31:0] pc,
                          input logic [31:0] im, input logic [31:0] r1);
    redirect_valid = v;
    NPCOp = op;
    redirect_pc = pc;
    imm = im;
    rs1_val = r1;
    tick();
    redirect_valid = 1'b0;
    NPCOp = 3'b000;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 30 && !id_valid; i++) tick();
    check(name, 32'(id_valid), 32'd1);
  endtask

  task automatic wait_two_outstanding(input string name);
    for (int i = 0; i < 30 && !(!imem_req && !id_valid && pend_addr.size() == 2); i++) tick();
    check(name, 32'(!imem_req && !id_valid && pend_addr.size() == 2), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, n0;
    tbl[0] = '{1'b1, 3'b001, 32'h0000_0010, 32'hFFFF_FFF8, 32'h0,         32'h0000_0008};
    tbl[1] = '{1'b1, 3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0,         32'h0000_0004};
    tbl[2] = '{1'b1, 3'b100, 32'h0000_0500, 32'h0000_0004, 32'h0000_1003, 32'h0000_1004};
    tbl[3] = '{1'b1, 3'b000, 32'h0000_0040, 32'h0000_0040, 32'h0,         32'h0000_1004};
    tbl[4] = '{1'b1, 3'b011, 32'h0000_0080, 32'h0000_0000, 32'h0,         32'h0000_1004};
    tbl[5] = '{1'b0, 3'b001, 32'h0000_0000, 32'h0000_0000, 32'h0,         32'h0000_1004};
    tbl[6] = '{1'b1, 3'b001, 32'h0000_2000, 32'h0000_0013, 32'h0,         32'h0000_2010};
    tbl[7] = '{1'b1, 3'b010, 32'h7FFF_FFF0, 32'h0000_0007, 32'h0,         32'h7FFF_FFF4};
    tbl[8] = '{1'b1, 3'b111, 32'h0000_0000, 32'h0000_0004, 32'h0,         32'h7FFF_FFF4};
    tbl[9] = '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0000};

    // reset release and streaming with a 1-cycle memory
    gnt_en = 1'b1; lat = 1; hold = 1'b0; id_ready = 1'b1;
    do_reset();
    repeat (20) tick();
    check("first_gnt_cycle", 32'(first_g), 32'd1);
    check("fetch_latency", 32'(first_v - first_g), 32'd2);
    check("stream_xfers", 32'(nxfer), 32'd12);
`ifdef IF_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'd12);
`endif

    // decode stall: credits cap grants, outputs hold, release drains in order
    id_ready = 1'b0;
    g0 = ngnt;
    for (int i = 0; i < 10; i++) begin
      if (id_valid) begin
        check("stall_id_pc", id_pc, exp_pc);
        check("stall_id_instr", id_instr, instr_of(exp_pc));
      end
      tick();
    end
    check("stall_grants_le_depth", 32'((ngnt - g0) <= 2), 32'd1);
    check("stall_req_low", 32'(imem_req), 32'd0);
    check("stall_id_valid", 32'(id_valid), 32'd1);
    id_ready = 1'b1;
    n0 = nxfer;
    repeat (10) tick();
    check("drain_progress", 32'((nxfer - n0) >= 3), 32'd1);

    // beq back to 0x08 with two responses outstanding
    hold = 1'b1;
    wait_two_outstanding("beq_setup");
    redirect(1'b1, 3'b001, 32'h10, 32'hFFFF_FFF8, 32'h0);
    exp_pc = 32'h8; exp_fetch = 32'h8;
    check("beq_flush_addr", imem_addr, 32'h8);
    check("beq_flush_req", 32'(imem_req), 32'd0);
    check("beq_flush_valid", 32'(id_valid), 32'd0);
    hold = 1'b0;
    wait_valid("beq_wait");
    check("beq_first_pc", id_pc, 32'h8);
    repeat (4) tick();

    // jalr and wrapping jal mid-stream
    redirect(1'b1, 3'b100, 32'h500, 32'h4, 32'h1003);
    exp_pc = 32'h1004; exp_fetch = 32'h1004;
    check("jalr_addr", imem_addr, 32'h1004);
    wait_valid("jalr_wait");
    check("jalr_first_pc", id_pc, 32'h1004);
    redirect(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h0);
    exp_pc = 32'h4; exp_fetch = 32'h4;
    check("jal_wrap_addr", imem_addr, 32'h4);
    wait_valid("jal_wait");
    check("jal_first_pc", id_pc, 32'h4);

    // NPCOp=000 is ignored; stream continues sequentially
    repeat (3) tick();
    n0 = nxfer;
    redirect(1'b1, 3'b000, 32'h40, 32'h100, 32'h0);
    repeat (8) tick();
    check("plus4_no_flush", 32'((nxfer - n0) >= 4), 32'd1);

    // response coincident with a redirect is discarded
    for (int i = 0; i < 10 && !imem_rvalid; i++) tick();
    check("coincident_rvalid_seen", 32'(imem_rvalid), 32'd1);
    redirect(1'b1, 3'b010, 32'h200, 32'h0, 32'h0);
    exp_pc = 32'h200; exp_fetch = 32'h200;
    wait_valid("coincident_wait");
    check("coincident_first_pc", id_pc, 32'h200);

    // redirect with a full buffer clears it
    id_ready = 1'b0;
    repeat (6) tick();
    check("full_before_redirect", 32'(id_valid), 32'd1);
    redirect(1'b1, 3'b100, 32'h0, 32'h10, 32'h301);
    exp_pc = 32'h310; exp_fetch = 32'h310;
    check("fifo_cleared", 32'(id_valid), 32'd0);
    id_ready = 1'b1;
    wait_valid("clear_wait");
    check("clear_first_pc", id_pc, 32'h310);
    repeat (3) tick();

    // asynchronous reset during FLUSH
    hold = 1'b1;
    wait_two_outstanding("flush_rst_setup");
    redirect(1'b1, 3'b001, 32'h100, 32'h40, 32'h0);
    check("flush_rst_target", imem_addr, 32'h140);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_req", 32'(imem_req), 32'd0);
    check("async_rst_valid", 32'(id_valid), 32'd0);
    check("async_rst_addr", imem_addr, 32'h0);
    hold = 1'b0;
    do_reset();
    repeat (15) tick();
    check("refetch_xfers", 32'(nxfer), 32'd8);

    // spurious rvalid, then redirect target table with grants held off
    gnt_en = 1'b0;
    do_reset();
    repeat (3) tick();
    check("idle_req", 32'(imem_req), 32'd1);
    check("idle_addr", imem_addr, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    tick();
    check("spurious_rvalid_ignored", 32'(id_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      redirect(tbl[i].rv, tbl[i].op, tbl[i].pc, tbl[i].imm, tbl[i].rs1);
      check("tbl_addr", imem_addr, tbl[i].exp);
      check("tbl_req", 32'(imem_req), 32'd1);
      check("tbl_valid", 32'(id_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
